// File: rtl/timer_ctrl_fsm.sv
// Countdown timer control sequencer: debounced key events, run/pause/clear/preset
// control of the digit chain, and a timed blinking alarm on terminal zero.

module timer_key_deb #(
  parameter int DEB_N = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);
  localparam int CW = (DEB_N > 1) ? $clog2(DEB_N) : 1;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_dly_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level must differ from the debounced level for DEB_N straight cycles to flip it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_N - 1)) deb_d = sync2_q;
      else                         cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_dly_q <= 1'b1;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      press_q   <= deb_dly_q & ~deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = press_q;
endmodule

module timer_ctrl_fsm #(
  parameter int DEB_N       = 500000,
  parameter int ALARM_TICKS = 300,
  parameter int BLINK_TICKS = 25
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [2:0] iKEY,
  input  logic [1:0] iSEL,
  input  logic [3:0] iDATA,
  input  logic       iTICK,
  input  logic       iZERO,
  output logic       oRUN,
  output logic       oCLR,
  output logic [3:0] oLOAD,
  output logic [3:0] oLOAD_DATA,
  output logic       oALARM,
  output logic       oLED,
  output logic [2:0] oSTATE
);
  localparam int TW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RUN   = 3'b001,
    PAUSE = 3'b010,
    ALARM = 3'b011
  } state_e;

  logic [2:0] press;

  for (genvar k = 0; k < 3; k++) begin : g_key
    timer_key_deb #(.DEB_N(DEB_N)) u_deb (
      .clk_i  (iCLK),
      .rst_i  (iRST),
      .key_i  (iKEY[k]),
      .press_o(press[k])
    );
  end

  state_e        state_q, state_d;
  logic          clr_q, clr_d;
  logic [3:0]    load_q, load_d;
  logic [3:0]    ldata_q, ldata_d;
  logic          run_q, alarm_q;
  logic          led_q, led_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          ev_clr, ev_pre, ev_start;
  logic [3:0]    clamp, load_vec;

  assign ev_clr   = press[0];
  assign ev_pre   = press[1];
  assign ev_start = press[2];

  // Odd selects are tens digits (0-5), even selects are units digits (0-9).
  always_comb begin
    if (iSEL[0]) clamp = (iDATA > 4'd5) ? 4'd5 : iDATA;
    else         clamp = (iDATA > 4'd9) ? 4'd9 : iDATA;
    load_vec = 4'b0001 << iSEL;
  end

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    load_d  = '0;
    ldata_d = '0;
    led_d   = led_q;
    tick_d  = tick_q;
    blink_d = blink_q;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (ev_clr) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (ev_start) begin
          if (!iZERO) state_d = RUN;
        end else if (ev_pre) begin
          load_d  = load_vec;
          ldata_d = clamp;
        end
      end
      RUN: begin
        if (ev_clr) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (iZERO) begin
          state_d = ALARM;
          tick_d  = '0;
          blink_d = '0;
          led_d   = 1'b1;
        end else if (ev_start) begin
          state_d = PAUSE;
        end
      end
      ALARM: begin
        if (|press) begin
          state_d = IDLE;
          led_d   = 1'b0;
        end else if (iTICK) begin
          if (tick_q == TW'(ALARM_TICKS - 1)) begin
            state_d = IDLE;
            led_d   = 1'b0;
          end else begin
            tick_d = tick_q + 1'b1;
            if (blink_q == BW'(BLINK_TICKS - 1)) begin
              blink_d = '0;
              led_d   = ~led_q;
            end else begin
              blink_d = blink_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
      load_q  <= '0;
      ldata_q <= '0;
      run_q   <= 1'b0;
      alarm_q <= 1'b0;
      led_q   <= 1'b0;
      tick_q  <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      load_q  <= load_d;
      ldata_q <= ldata_d;
      run_q   <= (state_d == RUN);
      alarm_q <= (state_d == ALARM);
      led_q   <= led_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  assign oRUN       = run_q;
  assign oCLR       = clr_q;
  assign oLOAD      = load_q;
  assign oLOAD_DATA = ldata_q;
  assign oALARM     = alarm_q;
  assign oLED       = led_q;
  assign oSTATE     = state_q;
endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Scoreboarded bench for timer_ctrl_fsm: a behavioural model predicts every cycle's
// outputs into a queue, a monitor pops and compares on the falling edge.

module tb_timer_ctrl_fsm;
  localparam int DEB_N       = 4;
  localparam int ALARM_TICKS = 6;
  localparam int BLINK_TICKS = 2;

  logic       iCLK, iRST, iTICK, iZERO;
  logic [2:0] iKEY;
  logic [1:0] iSEL;
  logic [3:0] iDATA;
  logic       oRUN, oCLR, oALARM, oLED;
  logic [3:0] oLOAD, oLOAD_DATA;
  logic [2:0] oSTATE;

  timer_ctrl_fsm #(.DEB_N(DEB_N), .ALARM_TICKS(ALARM_TICKS), .BLINK_TICKS(BLINK_TICKS)) dut (
    .iCLK(iCLK), .iRST(iRST), .iKEY(iKEY), .iSEL(iSEL), .iDATA(iDATA),
    .iTICK(iTICK), .iZERO(iZERO), .oRUN(oRUN), .oCLR(oCLR), .oLOAD(oLOAD),
    .oLOAD_DATA(oLOAD_DATA), .oALARM(oALARM), .oLED(oLED), .oSTATE(oSTATE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    int st, run, clr, load, ldata, alarm, led;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  logic [3:0] last_load, last_ldata;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: keys seen 2 cycles late, debounced level follows after DEB_N
  // consecutive differing cycles, a press event lands one cycle after a 1->0 flip.
  initial begin : model
    int   s1[3], s2[3], deb[3], dly[3], run_len[3], ev[3], nev[3];
    int   st, ticks, led, clr, load, ldata, lim;
    exp_t e;
    st = 0; ticks = 0; led = 0; clr = 0; load = 0; ldata = 0;
    for (int k = 0; k < 3; k++) begin
      s1[k] = 1; s2[k] = 1; deb[k] = 1; dly[k] = 1; run_len[k] = 0; ev[k] = 0;
    end
    forever begin
      @(posedge iCLK);
      if (iRST) begin
        st = 0; ticks = 0; led = 0; clr = 0; load = 0; ldata = 0;
        for (int k = 0; k < 3; k++) begin
          s1[k] = 1; s2[k] = 1; deb[k] = 1; dly[k] = 1; run_len[k] = 0; ev[k] = 0;
        end
      end else begin
        clr = 0; load = 0; ldata = 0;
        lim = iSEL[0] ? 5 : 9;
        case (st)
          0, 2: begin
            if (ev[0] != 0) begin clr = 1; st = 0; end
            else if (ev[2] != 0) begin if (!iZERO) st = 1; end
            else if (ev[1] != 0) begin
              load = 1 << iSEL;
              ldata = (int'(iDATA) > lim) ? lim : int'(iDATA);
            end
          end
          1: begin
            if (ev[0] != 0) begin clr = 1; st = 0; end
            else if (iZERO) begin st = 3; ticks = 0; led = 1; end
            else if (ev[2] != 0) st = 2;
          end
          default: begin
            if (ev[0] + ev[1] + ev[2] > 0) begin st = 0; led = 0; end
            else if (iTICK) begin
              ticks++;
              if (ticks == ALARM_TICKS) begin st = 0; led = 0; end
              else if (ticks % BLINK_TICKS == 0) led = 1 - led;
            end
          end
        endcase
        for (int k = 0; k < 3; k++) begin
          nev[k] = (dly[k] == 1 && deb[k] == 0) ? 1 : 0;
          dly[k] = deb[k];
          if (s2[k] != deb[k]) begin
            run_len[k]++;
            if (run_len[k] == DEB_N) begin deb[k] = s2[k]; run_len[k] = 0; end
          end else run_len[k] = 0;
          s2[k] = s1[k];
          s1[k] = int'(iKEY[k]);
          ev[k] = nev[k];
        end
      end
      e.st = st; e.run = (st == 1); e.clr = clr; e.load = load; e.ldata = ldata;
      e.alarm = (st == 3); e.led = led;
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (oLOAD != 4'd0) begin last_load = oLOAD; last_ldata = oLOAD_DATA; end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(oSTATE), e.st);
        chk("run",   int'(oRUN),   e.run);
        chk("clr",   int'(oCLR),   e.clr);
        chk("load",  int'(oLOAD),  e.load);
        chk("ldata", int'(oLOAD_DATA), e.ldata);
        chk("alarm", int'(oALARM), e.alarm);
        chk("led",   int'(oLED),   e.led);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic press(input int k, input int hold);
    iKEY[k] = 1'b0;
    cyc(hold);
    iKEY[k] = 1'b1;
    cyc(10);
  endtask

  initial begin : stim
    int dwell[3];
    int zdw;
    iRST = 1'b1; iKEY = 3'b111; iSEL = 2'd0; iDATA = 4'd0; iTICK = 1'b0; iZERO = 1'b0;
    last_load = '0; last_ldata = '0;
    cyc(3);
    iRST = 1'b0;
    cyc(2);

    // Bounce then stable press: oRUN rises exactly 8 cycles after the stable low.
    iKEY[2] = 1'b0; cyc(1);
    iKEY[2] = 1'b1; cyc(1);
    iKEY[2] = 1'b0; cyc(1);
    iKEY[2] = 1'b1; cyc(1);
    iKEY[2] = 1'b0;
    cyc(7);
    chk("start_latency_pre", int'(oRUN), 0);
    cyc(1);
    chk("start_latency", int'(oRUN), 1);
    cyc(100);
    chk("held_no_retrigger", int'(oSTATE), 1);
    iKEY[2] = 1'b1;
    cyc(10);

    // Terminal zero in RUN -> blinking alarm that times out without a clear.
    iZERO = 1'b1;
    for (int i = 0; i < 30; i++) begin
      iTICK = (i % 3 == 2);
      cyc(1);
    end
    iTICK = 1'b0; iZERO = 1'b0;
    chk("alarm_timeout_state", int'(oSTATE), 0);
    chk("alarm_timeout_alarm", int'(oALARM), 0);

    // Presets in PAUSE with clamping.
    press(2, 8); press(2, 8);
    chk("pause_state", int'(oSTATE), 2);
    iSEL = 2'b01; iDATA = 4'd9; last_load = '0;
    press(1, 8);
    chk("preset_tens_load", int'(last_load), 2);
    chk("preset_tens_data", int'(last_ldata), 5);
    iSEL = 2'b10; iDATA = 4'd12; last_load = '0;
    press(1, 8);
    chk("preset_units_load", int'(last_load), 4);
    chk("preset_units_data", int'(last_ldata), 9);
    press(0, 8);

    // Preset ignored in RUN; start ignored in IDLE when already zero.
    press(2, 8);
    last_load = '0;
    press(1, 8);
    chk("run_preset_ignored", int'(last_load), 0);
    press(0, 8);
    iZERO = 1'b1;
    press(2, 8);
    chk("idle_zero_start", int'(oSTATE), 0);
    iZERO = 1'b0;

    // Clear and start together in RUN.
    press(2, 8);
    iKEY = 3'b010; cyc(8);
    iKEY = 3'b111; cyc(10);
    chk("clr_start_state", int'(oSTATE), 0);

    // Reset mid-RUN while the start key bounces.
    press(2, 8);
    iKEY[2] = 1'b0; cyc(1);
    iKEY[2] = 1'b1; cyc(1);
    iKEY[2] = 1'b0; iRST = 1'b1; cyc(1);
    iRST = 1'b0;
    chk("reset_state", int'(oSTATE), 0);
    chk("reset_run", int'(oRUN), 0);
    iKEY[2] = 1'b1; cyc(1);
    iKEY[2] = 1'b0; cyc(1);
    iKEY[2] = 1'b1; cyc(12);

    // Randomized traffic: bouncy and clean presses, ticks, zero, occasional reset.
    for (int k = 0; k < 3; k++) dwell[k] = $urandom_range(1, 10);
    zdw = 20;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (dwell[k] == 0) begin
          iKEY[k] = ~iKEY[k];
          dwell[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : $urandom_range(5, 16);
        end else dwell[k]--;
      end
      if (zdw == 0) begin
        iZERO = ~iZERO;
        zdw = iZERO ? $urandom_range(1, 40) : $urandom_range(10, 60);
      end else zdw--;
      iTICK = ($urandom_range(0, 2) == 0);
      iSEL  = 2'($urandom);
      iDATA = 4'($urandom);
      iRST  = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    iRST = 1'b0; iKEY = 3'b111; iTICK = 1'b0; iZERO = 1'b0;
    cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/timer_ctrl_fsm.md
Name: timer_ctrl_fsm

Overview:
Control sequencer for the 6-digit countdown timer datapath (10ms/100ms/1s/10s/1min/10min down-counters). It turns raw active-low push keys into debounced single-cycle events and drives the datapath's count enable, clear and per-digit preset loads. It also detects terminal zero and generates a timed, blinking alarm. It sits between the board keys/switches and the counter chain and replaces the direct key wiring.

Parameters:
DEB_N, 500000, cycles a synchronized key level must stay stable before the debounced level changes (10ms at 50MHz).
ALARM_TICKS, 300, iTICK pulses the alarm stays active before auto-return to IDLE.
BLINK_TICKS, 25, iTICK pulses per oLED half-period while in ALARM.

Ports:
iCLK  in  1  system clock
iRST  in  1  synchronous active-high reset
iKEY  in  3  raw keys, active-low: [0]=clear, [1]=preset, [2]=start/pause
iSEL  in  2  preset digit select: 00=1s, 01=10s, 10=1min, 11=10min
iDATA  in  4  raw preset value from switches
iTICK  in  1  one-cycle 10ms enable from the datapath prescaler
iZERO  in  1  high when all six datapath digits are zero
oRUN  out  1  count enable to the counter chain
oCLR  out  1  one-cycle clear pulse to the counter chain
oLOAD  out  4  one-hot one-cycle preset load strobe, bit index = iSEL
oLOAD_DATA  out  4  clamped preset value, valid while oLOAD != 0
oALARM  out  1  alarm active
oLED  out  1  alarm blink output
oSTATE  out  3  current state encoding, for debug/LED display

Behaviour:
- Reset (iRST high at a clock edge): state=IDLE. oRUN=0, oCLR=0, oLOAD=0, oLOAD_DATA=0, oALARM=0, oLED=0. Debounced levels=1 (released). Sync FFs=1. All counters=0. Reset wins over every other input, including mid-debounce and mid-alarm.
- Key path, per key: 2-FF synchronizer, then debounce counter. The counter increments while synced != debounced and clears when they are equal. When the count reaches DEB_N-1 the debounced level takes the synced value. A press event is a one-cycle registered pulse on a debounced 1->0 transition. Release generates no event. Exactly one event per press regardless of hold time.
- Simultaneous events, priority: clear > start > preset. Lower-priority events in the same cycle are dropped.
- State encoding: IDLE=000, RUN=001, PAUSE=010, ALARM=011.
- IDLE:
  - clear -> oCLR pulse, stay IDLE.
  - start with iZERO=0 -> RUN. Start with iZERO=1 is ignored.
  - preset -> load pulse, stay IDLE.
- RUN:
  - oRUN=1.
  - clear -> oCLR pulse, go to IDLE.
  - start -> PAUSE.
  - iZERO=1 -> ALARM. iZERO has priority over a start event in the same cycle; clear still wins over iZERO.
  - preset is ignored.
- PAUSE:
  - oRUN=0.
  - clear -> oCLR pulse, go to IDLE.
  - start with iZERO=0 -> RUN.
  - preset -> load pulse, stay PAUSE.
- ALARM:
  - oALARM=1. The tick counter clears on entry.
  - oLED toggles every BLINK_TICKS ticks, starting at 1 on entry.
  - Return to IDLE on any key event, or when the count reaches ALARM_TICKS. Neither case produces oCLR.
  - On exit, oALARM=0 and oLED=0.
- Outputs are registered. oRUN, oALARM and oSTATE change on the edge after the event/iZERO cycle. oCLR and oLOAD are high for exactly that one following cycle.
- Load pulse: oLOAD = 1<<iSEL, with iSEL sampled in the event cycle. oLOAD_DATA is registered in the same cycle as oLOAD.
  - Clamp for iSEL=01 or 11 (tens digits, range 0-5): value = min(iDATA,5).
  - Clamp for iSEL=00 or 10 (units digits, range 0-9): value = min(iDATA,9).
- Total latency from a key going low to its output effect: 2 (sync) + DEB_N (debounce) + 1 (event) + 1 (output) cycles.

Test Plan:
Use DEB_N=4, ALARM_TICKS=6, BLINK_TICKS=2 throughout.
- Reset mid-RUN with iKEY[2] bouncing -> next cycle state=000, all outputs 0. No event fires after release of reset until a clean stable press.
- iKEY[2] bounce 1-0-1-0 at 1-cycle intervals, then held low for 10 cycles, with iZERO=0 -> exactly one start event. oRUN=1 at cycle 2+4+2 after the stable low. Holding low for 100 more cycles causes no further transition.
- RUN, then iZERO=1 -> ALARM (011), oALARM=1, oLED toggles every 2 iTICK pulses. After 6 iTICK pulses -> IDLE, oALARM=0, oLED=0, oCLR never asserted.
- PAUSE, iSEL=01, iDATA=9, preset press -> oLOAD=0010 for one cycle, oLOAD_DATA=5. Repeat with iSEL=10, iDATA=12 -> oLOAD=0100, oLOAD_DATA=9.
- RUN with a preset press -> oLOAD stays 0000. IDLE with iZERO=1 and a start press -> state stays IDLE, oRUN=0.
- Clear and start debounced in the same cycle while in RUN -> one oCLR pulse, state=IDLE, no PAUSE visited.
